// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem request, redirect (jr/jump/branch), IF/ID register.
// Ports: clk, rst_n | stall, flush | jump_register, jr_target, jump,
//   branch_taken, branch_pc4, branch_offset | imem_req, imem_addr,
//   imem_rdata, imem_ready | if_id_instr, if_id_pc4, if_id_valid,
//   opcode, funct | perf_fetched, perf_bubbles (FETCH_PERF_CNT_EN only).
module fetch_stage #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                jump_register,
  input  logic [PC_WIDTH-1:0] jr_target,
  input  logic                jump,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_pc4,
  input  logic [PC_WIDTH-1:0] branch_offset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc4,
  output logic                if_id_valid,
  output logic [5:0]          opcode,
  output logic [5:0]          funct
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         buf_instr_q, buf_instr_d;
  logic [PC_WIDTH-1:0] buf_pc4_q, buf_pc4_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc4_q, pc4_d;
  logic                valid_q, valid_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                ld_valid;
  logic                ld_bubble;
  logic [31:0]         ld_instr;
  logic [PC_WIDTH-1:0] ld_pc4;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);
  assign redirect = jump_register | jump | branch_taken;

  // jr wins over jump, jump over branch
  always_comb begin
    target = '0;
    if (jump_register) begin
      target = jr_target;
    end else if (jump) begin
      target = {pc4_q[PC_WIDTH-1:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      target = branch_pc4 + (branch_offset << 2);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    ld_valid    = 1'b0;
    ld_bubble   = 1'b0;
    ld_instr    = '0;
    ld_pc4      = '0;
    if (redirect) begin
      // any returning word is dropped; stall is overridden
      pc_d        = target;
      buf_instr_d = '0;
      buf_pc4_d   = '0;
      ld_bubble   = 1'b1;
      state_d     = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            if (!stall) begin
              ld_valid = 1'b1;
              ld_instr = imem_rdata;
              ld_pc4   = pc_plus4;
              pc_d     = pc_plus4;
            end else begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end
          end else if (!stall) begin
            ld_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ld_valid    = 1'b1;
            ld_instr    = buf_instr_q;
            ld_pc4      = buf_pc4_q;
            pc_d        = pc_plus4;
            buf_instr_d = '0;
            buf_pc4_d   = '0;
            state_d     = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      // flushed word is dropped, PC still advances past it
      if (flush) begin
        ld_valid  = 1'b0;
        ld_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (ld_valid) begin
      instr_d = ld_instr;
      pc4_d   = ld_pc4;
      valid_d = 1'b1;
    end else if (ld_bubble) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (ld_valid) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (ld_bubble) begin
        bubbles_q <= bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule
